// File: rtl/seg7_pkg.sv
// Seven-segment types and hex glyph constants shared by the counter/display block.
// Segment order is {dp, g, f, e, d, c, b, a}.
package seg7_pkg;

   typedef logic [7:0] seg7_t;

   localparam seg7_t SEG_0  = 8'h3F;
   localparam seg7_t SEG_1  = 8'h06;
   localparam seg7_t SEG_2  = 8'h5B;
   localparam seg7_t SEG_3  = 8'h4F;
   localparam seg7_t SEG_4  = 8'h66;
   localparam seg7_t SEG_5  = 8'h6D;
   localparam seg7_t SEG_6  = 8'h7D;
   localparam seg7_t SEG_7  = 8'h07;
   localparam seg7_t SEG_8  = 8'h7F;
   localparam seg7_t SEG_9  = 8'h6F;
   localparam seg7_t SEG_A  = 8'h77;
   localparam seg7_t SEG_B  = 8'h7C;
   localparam seg7_t SEG_C  = 8'h39;
   localparam seg7_t SEG_D  = 8'h5E;
   localparam seg7_t SEG_E  = 8'h79;
   localparam seg7_t SEG_F  = 8'h71;
   localparam seg7_t SEG_DP = 8'h80;

endpackage

// File: rtl/updown_hex_counter_mux_if.sv
// Control/status bundle of the up/down hex counter: switch-side controls in,
// binary count, terminal-count pulse and scanned 7-segment drive out.
interface updown_hex_counter_mux_if #(
   parameter int unsigned NDIGITS = 2
);
   import seg7_pkg::*;

   localparam int unsigned CW = 4 * NDIGITS;

   logic               en;
   logic               dir;
   logic               sat_mode;
   logic               load;
   logic [CW-1:0]      load_val;
   logic [CW-1:0]      count;
   logic               tc;
   seg7_t              seg;
   logic [NDIGITS-1:0] dig_sel;

   modport master (
      output en, dir, sat_mode, load, load_val,
      input  count, tc, seg, dig_sel
   );

   modport slave (
      input  en, dir, sat_mode, load, load_val,
      output count, tc, seg, dig_sel
   );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment glyph decoder (decimal point always off).
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] hex_i,
   output seg7_t      seg_o
);

   always_comb begin
      seg_o = SEG_0;
      unique case (hex_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
      endcase
   end

endmodule

// File: rtl/updown_hex_counter_mux.sv
// Multi-digit modulo up/down counter with load, wrap/saturate and a scanned hex display.
// Optional macro SEG_DP_DIR_EN lights the digit-0 decimal point while counting down.
module updown_hex_counter_mux
   import seg7_pkg::*;
#(
   parameter int unsigned NDIGITS  = 2,
   parameter int unsigned MODULO   = 256,
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic                     clk_2,
   input  logic                     reset,
   updown_hex_counter_mux_if.slave  bus
);

   localparam int unsigned CW = 4 * NDIGITS;
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   // One extra bit so MODULO == 16**NDIGITS still compares correctly.
   localparam logic [CW:0]   ModW     = (CW + 1)'(MODULO);
   localparam logic [CW-1:0] MaxVal   = CW'(MODULO - 1);
   localparam logic [SW-1:0] ScanLast = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IdxLast  = IW'(NDIGITS - 1);

   logic [CW-1:0]      count_q, count_d;
   logic               tc_q, tc_d;
   logic [SW-1:0]      scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]      scan_idx_q, scan_idx_d;
   logic [NDIGITS-1:0] dig_sel_q, dig_sel_d;
   seg7_t              seg_q, seg_d;
   logic [3:0]         nibble;
   seg7_t              nib_seg;

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (bus.load) begin
         count_d = ({1'b0, bus.load_val} >= ModW) ? MaxVal : bus.load_val;
      end else if (bus.en) begin
         if (!bus.dir) begin
            if (count_q == MaxVal) begin
               tc_d = 1'b1;
               if (!bus.sat_mode) count_d = '0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               tc_d = 1'b1;
               if (!bus.sat_mode) count_d = MaxVal;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == ScanLast) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == IdxLast) ? '0 : scan_idx_q + 1'b1;
      end
   end

   // Display reflects the count held before the edge: one cycle of latency.
   assign nibble = 4'(count_q >> {scan_idx_q, 2'b00});

   hex_to_seg7 u_hex_to_seg7 (
      .hex_i (nibble),
      .seg_o (nib_seg)
   );

   always_comb begin
      dig_sel_d             = '0;
      dig_sel_d[scan_idx_q] = 1'b1;
      seg_d                 = nib_seg;
`ifdef SEG_DP_DIR_EN
      if ((scan_idx_q == '0) && bus.dir) seg_d = nib_seg | SEG_DP;
`endif
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         count_q    <= '0;
         tc_q       <= 1'b0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         dig_sel_q  <= NDIGITS'(1);
         seg_q      <= SEG_0;
      end else begin
         count_q    <= count_d;
         tc_q       <= tc_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         dig_sel_q  <= dig_sel_d;
         seg_q      <= seg_d;
      end
   end

   assign bus.count   = count_q;
   assign bus.tc      = tc_q;
   assign bus.seg     = seg_q;
   assign bus.dig_sel = dig_sel_q;

endmodule

// File: tb/tb_updown_hex_counter_mux.sv
// Scoreboard bench for updown_hex_counter_mux (NDIGITS=2, MODULO=60, SCAN_DIV=4);
// honours SEG_DP_DIR_EN when computing expected decimal-point bits.
module tb_updown_hex_counter_mux;

`ifdef SEG_DP_DIR_EN
   localparam logic [7:0] DpByte = 8'h80;
`else
   localparam logic [7:0] DpByte = 8'h00;
`endif

   logic clk_2 = 1'b0;
   logic reset = 1'b1;
   always #5 clk_2 = ~clk_2;

   updown_hex_counter_mux_if #(.NDIGITS(2)) bus ();

   updown_hex_counter_mux #(
      .NDIGITS  (2),
      .MODULO   (60),
      .SCAN_DIV (4)
   ) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string      name;
      logic [7:0] cnt;
      logic       tc;
      bit         chk_disp;
      logic [1:0] dig;
      logic [7:0] seg;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue what the outputs must show after the edge.
   task automatic step(input string name, input bit rst, input bit ld, input logic [7:0] lv,
                       input bit en, input bit dir, input bit sat,
                       input logic [7:0] ecnt, input bit etc,
                       input bit chk, input logic [1:0] edig, input logic [7:0] eseg);
      exp_t e;
      @(negedge clk_2);
      reset        = rst;
      bus.load     = ld;
      bus.load_val = lv;
      bus.en       = en;
      bus.dir      = dir;
      bus.sat_mode = sat;
      e.name       = name;
      e.cnt        = ecnt;
      e.tc         = etc;
      e.chk_disp   = chk;
      e.dig        = edig;
      e.seg        = eseg;
      sb_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk_2);
         #1;
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp({e.name, ":count"}, bus.count, e.cnt);
            cmp({e.name, ":tc"}, {7'd0, bus.tc}, {7'd0, e.tc});
            if (e.chk_disp) begin
               cmp({e.name, ":dig_sel"}, {6'd0, bus.dig_sel}, {6'd0, e.dig});
               cmp({e.name, ":seg"}, bus.seg, e.seg);
            end
         end
      end
   end

   initial begin
      bus.en = 1'b0; bus.dir = 1'b0; bus.sat_mode = 1'b0;
      bus.load = 1'b0; bus.load_val = 8'h00;

      //    name         rst ld lv     en dir sat cnt    tc chk dig    seg
      step("rst0",       1, 0, 8'd0,  0, 0, 0, 8'd0,  0, 1, 2'b01, 8'h3F);
      step("rst1",       1, 0, 8'd0,  0, 0, 0, 8'd0,  0, 1, 2'b01, 8'h3F);
      // Up count through the modulo wrap
      step("ld58",       0, 1, 8'd58, 0, 0, 0, 8'd58, 0, 0, 2'b00, 8'h00);
      step("up59",       0, 0, 8'd0,  1, 0, 0, 8'd59, 0, 0, 2'b00, 8'h00);
      step("up_wrap",    0, 0, 8'd0,  1, 0, 0, 8'd0,  1, 0, 2'b00, 8'h00);
      step("up1",        0, 0, 8'd0,  1, 0, 0, 8'd1,  0, 0, 2'b00, 8'h00);
      step("idle",       0, 0, 8'd0,  0, 0, 0, 8'd1,  0, 0, 2'b00, 8'h00);
      // Down wrap, then saturate at both bounds
      step("ld0",        0, 1, 8'd0,  0, 0, 0, 8'd0,  0, 0, 2'b00, 8'h00);
      step("dn_wrap",    0, 0, 8'd0,  1, 1, 0, 8'd59, 1, 0, 2'b00, 8'h00);
      step("dn58",       0, 0, 8'd0,  1, 1, 0, 8'd58, 0, 0, 2'b00, 8'h00);
      step("ld0b",       0, 1, 8'd0,  0, 0, 0, 8'd0,  0, 0, 2'b00, 8'h00);
      step("sat_lo0",    0, 0, 8'd0,  1, 1, 1, 8'd0,  1, 0, 2'b00, 8'h00);
      step("sat_lo1",    0, 0, 8'd0,  1, 1, 1, 8'd0,  1, 0, 2'b00, 8'h00);
      step("sat_idle",   0, 0, 8'd0,  0, 1, 1, 8'd0,  0, 0, 2'b00, 8'h00);
      step("ld59",       0, 1, 8'd59, 0, 0, 1, 8'd59, 0, 0, 2'b00, 8'h00);
      step("sat_hi",     0, 0, 8'd0,  1, 0, 1, 8'd59, 1, 0, 2'b00, 8'h00);
      step("dir_flip",   0, 0, 8'd0,  1, 1, 1, 8'd58, 0, 0, 2'b00, 8'h00);
      // Load clamps and wins over enable
      step("ld_clamp",   0, 1, 8'h3C, 1, 0, 0, 8'd59, 0, 0, 2'b00, 8'h00);
      step("ld_ff",      0, 1, 8'hFF, 0, 0, 0, 8'd59, 0, 0, 2'b00, 8'h00);
      step("clamp_wrap", 0, 0, 8'd0,  1, 0, 0, 8'd0,  1, 0, 2'b00, 8'h00);
      // Display scan from a known scan phase
      step("rst_d",      1, 0, 8'd0,  0, 0, 0, 8'd0,  0, 1, 2'b01, 8'h3F);
      step("ld2a",       0, 1, 8'h2A, 0, 0, 0, 8'h2A, 0, 1, 2'b01, 8'h3F);
      for (int i = 0; i < 3; i++)
         step("scan_d0",  0, 0, 8'd0,  0, 0, 0, 8'h2A, 0, 1, 2'b01, 8'h77);
      for (int i = 0; i < 4; i++)
         step("scan_d1",  0, 0, 8'd0,  0, 0, 0, 8'h2A, 0, 1, 2'b10, 8'h5B);
      for (int i = 0; i < 4; i++)
         step("scan_dp0", 0, 0, 8'd0,  0, 1, 0, 8'h2A, 0, 1, 2'b01, 8'h77 | DpByte);
      step("scan_dp1",   0, 0, 8'd0,  0, 1, 0, 8'h2A, 0, 1, 2'b10, 8'h5B);
      // Reset mid-count overrides load/en
      step("rst_mid",    1, 0, 8'd0,  0, 0, 0, 8'd0,  0, 1, 2'b01, 8'h3F);
      step("ld29",       0, 1, 8'd29, 0, 0, 0, 8'd29, 0, 0, 2'b00, 8'h00);
      step("up30",       0, 0, 8'd0,  1, 0, 0, 8'd30, 0, 0, 2'b00, 8'h00);
      step("rst_cnt",    1, 1, 8'd5,  1, 1, 0, 8'd0,  0, 1, 2'b01, 8'h3F);
      step("post_rst",   0, 0, 8'd0,  0, 1, 0, 8'd0,  0, 1, 2'b01, 8'h3F | DpByte);
      step("ld59b",      0, 1, 8'd59, 0, 0, 0, 8'd59, 0, 0, 2'b00, 8'h00);
      step("rst_tc",     1, 0, 8'd0,  1, 0, 0, 8'd0,  0, 1, 2'b01, 8'h3F);

      @(negedge clk_2);
      reset   = 1'b0;
      bus.en  = 1'b0;
      bus.load = 1'b0;
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk_2);
      #2;
      cmp("drain", 8'(sb_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
